// File: rtl/result_requant_if.sv
// Bundle of the filter-result input and the sample output handshake of result_requant.
// Latency: none (wires only).
// Backpressure: i_ready from the serializer gates FIFO reads; the filter side has no ready.
interface result_requant_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   // Filter side
   logic [43:0]   i_result;
   logic          i_valid;
   logic [4:0]    i_shift;

   // Serializer side
   logic [23:0]   o_sample;
   logic          o_valid;
   logic          i_ready;

   // Status
   logic          o_clip;
   logic          o_overflow;
   logic [LW-1:0] o_level;
   logic [15:0]   o_clip_count;

   // Driver of results and ready (filter + serializer, or a testbench)
   modport master (
      output i_result, i_valid, i_shift, i_ready,
      input  o_sample, o_valid, o_clip, o_overflow, o_level, o_clip_count
   );

   // The requantizer itself
   modport slave (
      input  i_result, i_valid, i_shift, i_ready,
      output o_sample, o_valid, o_clip, o_overflow, o_level, o_clip_count
   );
endinterface

// File: rtl/result_requant.sv
// Requantizes 44-bit FIR results to 24-bit samples (round-half-up shift, saturation) into a small FIFO.
// Latency: i_valid at edge E -> sample in FIFO, visible on o_valid/o_level/o_sample after edge E+3.
// Backpressure: i_ready stalls only FIFO reads; input never stalls, a full FIFO drops (o_overflow sticky).
// Optional feature: define REQUANT_CLIP_CNT_EN to build the saturating clipped-sample counter.
module result_requant #(
   parameter int DEPTH = 4
) (
   input logic             i_clk,
   input logic             i_rst_n,
   result_requant_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [4:0]    SHIFT_MAX = 5'd20;

   // Input capture: the filter's ready pulse and its operands
   logic               in_vld_q, in_vld_d;
   logic [43:0]        in_res_q, in_res_d;
   logic [4:0]         in_shift_q, in_shift_d;

   // Stage 1: rounded, scaled value (45 bits holds the result plus the rounding carry)
   logic               s1_vld_q, s1_vld_d;
   logic signed [44:0] s1_dat_q, s1_dat_d;
   logic [4:0]         shift_sat;
   logic [44:0]        rnd;
   logic signed [44:0] sum;

   // Stage 2: saturated 24-bit sample
   logic               s2_vld_q, s2_vld_d;
   logic [23:0]        s2_dat_q, s2_dat_d;
   logic               s2_clip_q, s2_clip_d;

   // FIFO storage and first-word register
   logic [23:0]        mem_q [DEPTH];
   logic [23:0]        mem_d [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic [23:0]        sample_q, sample_d;
   logic               clip_q, clip_d;
   logic               overflow_q, overflow_d;

   logic               pop;
   logic               full;
   logic               push;
   logic               drop;

   // Capture operands only on a valid pulse so idle cycles do not toggle the datapath
   always_comb begin
      in_vld_d   = bus.i_valid;
      in_res_d   = in_res_q;
      in_shift_d = in_shift_q;
      if (bus.i_valid) begin
         in_res_d   = bus.i_result;
         in_shift_d = bus.i_shift;
      end
   end

   // Stage 1: clamp shift to 20, add half an LSB of the result, arithmetic shift right
   always_comb begin
      shift_sat = (in_shift_q > SHIFT_MAX) ? SHIFT_MAX : in_shift_q;
      rnd       = '0;
      if (shift_sat != 5'd0) begin
         rnd = 45'd1 << (shift_sat - 5'd1);
      end
      sum       = {in_res_q[43], in_res_q} + rnd;
      s1_dat_d  = sum >>> shift_sat;
      s1_vld_d  = in_vld_q;
   end

   // Stage 2: saturate to the signed 24-bit range and flag when it happened
   always_comb begin
      s2_vld_d  = s1_vld_q;
      s2_dat_d  = s1_dat_q[23:0];
      s2_clip_d = 1'b0;
      if (s1_dat_q > 45'sd8388607) begin
         s2_dat_d  = 24'h7FFFFF;
         s2_clip_d = 1'b1;
      end else if (s1_dat_q < -45'sd8388608) begin
         s2_dat_d  = 24'h800000;
         s2_clip_d = 1'b1;
      end
   end

   // FIFO control: a read frees the slot a same-edge write needs, so full+pop still accepts
   always_comb begin
      pop  = (level_q != '0) && bus.i_ready;
      full = (level_q == LVL_FULL);
      push = s2_vld_q && (!full || pop);
      drop = s2_vld_q && full && !pop;
   end

   // FIFO state update: storage, pointers, occupancy and the registered head word
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = s2_dat_q;
      end
      wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);

      // Head word: next stored entry after a pop, or the incoming sample when it
      // lands in an empty (or just-emptied) FIFO; otherwise hold the last value.
      sample_d = sample_q;
      if (pop) begin
         if (level_q > LVL_ONE) begin
            sample_d = mem_q[rd_ptr_q + PTR_ONE];
         end else if (push) begin
            sample_d = s2_dat_q;
         end
      end else if ((level_q == '0) && push) begin
         sample_d = s2_dat_q;
      end

      // Clip pulses for every clipped stage-2 sample, written or dropped
      clip_d     = s2_vld_q && s2_clip_q;
      overflow_d = overflow_q || drop;
   end

   // All pipeline and FIFO state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         in_vld_q   <= 1'b0;
         in_res_q   <= '0;
         in_shift_q <= '0;
         s1_vld_q   <= 1'b0;
         s1_dat_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_dat_q   <= '0;
         s2_clip_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         sample_q   <= '0;
         clip_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         in_vld_q   <= in_vld_d;
         in_res_q   <= in_res_d;
         in_shift_q <= in_shift_d;
         s1_vld_q   <= s1_vld_d;
         s1_dat_q   <= s1_dat_d;
         s2_vld_q   <= s2_vld_d;
         s2_dat_q   <= s2_dat_d;
         s2_clip_q  <= s2_clip_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         sample_q   <= sample_d;
         clip_q     <= clip_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef REQUANT_CLIP_CNT_EN
   logic [15:0] clip_cnt_q, clip_cnt_d;

   // Saturating count of clip pulses, cleared only by reset
   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (clip_q && (clip_cnt_q != 16'hFFFF)) begin
         clip_cnt_d = clip_cnt_q + 16'd1;
      end
   end

   // Counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clip_cnt_q <= '0;
      end else begin
         clip_cnt_q <= clip_cnt_d;
      end
   end

   assign bus.o_clip_count = clip_cnt_q;
`else
   assign bus.o_clip_count = 16'd0;
`endif

   assign bus.o_sample   = sample_q;
   assign bus.o_valid    = (level_q != '0);
   assign bus.o_clip     = clip_q;
   assign bus.o_overflow = overflow_q;
   assign bus.o_level    = level_q;
endmodule

// File: doc/result_requant.md
# result_requant

Downstream stage of the 12-tap FIR filter. Takes each 44-bit signed accumulator result and its one-cycle ready pulse, and converts it back to a 24-bit audio sample. The conversion applies a runtime-selected arithmetic right shift with round-half-up, then saturates to 24 bits. Samples are buffered in a small FIFO and delivered to the output serializer over a valid/ready handshake.

## Interface
- DEPTH, 4, FIFO depth in samples; power of two, 2..16.
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_result  in  44  signed two's-complement filter result.
- i_valid  in  1  one-cycle pulse; i_result is valid in that cycle (driven from the filter's o_ready).
- i_shift  in  5  right-shift amount, 0..20; sampled together with i_result.
- o_sample  out  24  signed output sample at the FIFO head.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  downstream accepts o_sample when o_valid && i_ready.
- o_clip  out  1  one-cycle pulse: the sample just written was saturated.
- o_overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_clip_count  out  16  saturated-sample counter (see Configuration).

## Operation
- Stage 1 (register):
  - Sign-extend i_result to 45 bits.
  - Add the rounding constant 2^(i_shift-1) when i_shift>0; add 0 otherwise.
  - Arithmetic-shift right by i_shift.
  - Latch a stage-1 valid bit.
- i_shift>20 is treated as 20.
- Stage 2 (register):
  - Saturate to 24 bits: values >8388607 become 24'h7FFFFF; values <-8388608 become 24'h800000.
  - Set the stage-2 clip flag whenever saturation occurred.
- FIFO write: a stage-2 valid sample is written on the next edge.
  - Full and no simultaneous read: the sample is dropped and o_overflow sets.
  - Full with a simultaneous read: the write is accepted and o_level stays DEPTH.
- o_clip pulses for one cycle on the write edge of a clipped sample. It also pulses for a clipped sample that is dropped.
- FIFO read: pop on any edge where o_valid && i_ready.
  - o_sample always shows the head entry (first-word registered).
  - With o_valid low, o_sample holds its last value.
- Empty FIFO: no bypass. Read pointer does not move.
- Pointers wrap modulo DEPTH. o_level equals writes minus reads.
- Back-to-back i_valid on consecutive cycles is fully supported (pipeline throughput 1/cycle).
- Reset values:
  - o_sample=0, o_valid=0, o_clip=0, o_overflow=0, o_level=0, o_clip_count=0.
  - Pipeline valids cleared; FIFO pointers at 0.
- Reset mid-operation discards every in-flight and buffered sample. The first post-reset i_valid behaves as from power-up.

## Timing
- Latency: i_valid sampled at edge E → o_valid high after edge E+3 when the FIFO was empty.
- o_level increments at E+3.
- o_clip is high during the cycle after E+3.
- o_overflow rises after the dropping edge E+3 and stays high until reset.
- Pop at edge P: o_level decrements after P; the next entry appears on o_sample after P.
- o_valid falls after P when that pop empties the FIFO.

## Configuration
- Macro: REQUANT_CLIP_CNT_EN.
- Defined: o_clip_count increments on every o_clip pulse and saturates at 16'hFFFF. It clears only on reset.
- Undefined: the counter logic is not built. o_clip_count is tied to 16'd0 and the port remains for a stable interface.

## Test plan
- Rounding and scaling, with i_shift=15:
  - i_result=32768 → o_sample=1.
  - i_result=16384 → 1.
  - i_result=16383 → 0.
  - i_result=-16384 → 0.
  - i_result=-16385 → -1 (24'hFFFFFF).
  - o_valid is seen 3 edges after i_valid.
- Saturation, with i_shift=15:
  - i_result=2^40 → 24'h7FFFFF with o_clip pulse.
  - i_result=-2^40 → 24'h800000 with o_clip pulse.
  - With the macro defined, o_clip_count=2 afterwards.
- Overflow, DEPTH=4, i_ready held 0:
  - Five i_valid pulses with values 1..5 → o_level=4, o_overflow=1.
  - Releasing i_ready then pops 1,2,3,4 in order; 5 is never output.
- Simultaneous read/write when full: FIFO holds 4 entries, i_ready=1 on the cycle a stage-2 sample arrives → no drop, o_level stays 4, o_overflow stays 0.
- Throughput: i_valid asserted for 8 consecutive cycles with i_ready=1 and i_shift=0, values 0..7 → outputs 0..7 in order, o_level never exceeds 1.
- Reset mid-operation: assert i_rst_n low with 3 samples buffered and 2 in flight → all outputs at reset values next cycle. After release, the next single i_valid yields exactly one sample.
